// File: rtl/panel_input_if.sv
// Board-side bundle for panel_input: raw switch/button pins in, conditioned
// controls and CPU clock-enable status out.
interface panel_input_if #(
  parameter int NUM_SW  = 16,
  parameter int NUM_BTN = 5
) ();
  logic [NUM_SW-1:0]  sw_raw;
  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_SW-1:0]  sw_sync;
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_press;
  logic [NUM_BTN-1:0] btn_release;
  logic               cpu_en;
  logic               halted;
  logic [31:0]        en_count;

  modport master (
    output sw_raw, btn_raw,
    input  sw_sync, btn_level, btn_press, btn_release, cpu_en, halted, en_count
  );

  modport slave (
    input  sw_raw, btn_raw,
    output sw_sync, btn_level, btn_press, btn_release, cpu_en, halted, en_count
  );
endinterface

// File: rtl/panel_input.sv
// panel_input: switch synchronizers, button debouncers with press/release pulses and
// the run/halt/single-step FSM driving cpu_en. Auto-repeat step: PANEL_INPUT_AUTOREPEAT_EN.
module panel_input #(
  parameter int NUM_SW          = 16,
  parameter int NUM_BTN         = 5,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int RUN_SW          = 0,
  parameter int STEP_BTN        = 0,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_PERIOD   = 16
) (
  input  logic         clock,
  input  logic         reset,
  panel_input_if.slave io
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {
    S_HALT,
    S_RUN,
    S_STEP
  } state_t;

  logic [NUM_SW-1:0]  sw_s1, sw_s2;
  logic [NUM_BTN-1:0] btn_s1, btn_s2;
  logic [NUM_BTN-1:0] level_q, press_q, rel_q;
  logic [DB_W-1:0]    db_cnt [NUM_BTN];

  state_t      state, state_next;
  logic        cpu_en_q;
  logic [31:0] en_count_q;
  logic        run_sw;
  logic        step_req;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the two synchronizer stages.
  always_ff @(posedge clock) begin
    if (reset) begin
      sw_s1   <= '0;
      sw_s2   <= '0;
      btn_s1  <= '0;
      btn_s2  <= '0;
      level_q <= '0;
      press_q <= '0;
      rel_q   <= '0;
      // NOTE: the debounce counter array is reset explicitly; a press in flight
      // at reset must restart its full stable-time count afterwards.
      for (int i = 0; i < NUM_BTN; i++) db_cnt[i] <= '0;
    end else begin
      sw_s1   <= io.sw_raw;
      sw_s2   <= sw_s1;
      btn_s1  <= io.btn_raw;
      btn_s2  <= btn_s1;
      press_q <= '0;
      rel_q   <= '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        if (btn_s2[i] == level_q[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          db_cnt[i]  <= '0;
          level_q[i] <= btn_s2[i];
          press_q[i] <= btn_s2[i];
          rel_q[i]   <= ~btn_s2[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign run_sw = sw_s2[RUN_SW];

`ifdef PANEL_INPUT_AUTOREPEAT_EN
  localparam int RPT_W = $clog2(REPEAT_DELAY + 1);

  logic [RPT_W-1:0] rpt_cnt;
  logic             rpt_fire;

  assign rpt_fire = (state == S_HALT) && level_q[STEP_BTN] &&
                    (rpt_cnt == RPT_W'(REPEAT_DELAY - 1));

  // Counts held cycles since the debounced press; rewinds by one period after each fire.
  always_ff @(posedge clock) begin
    if (reset) begin
      rpt_cnt <= '0;
    end else if (!level_q[STEP_BTN] || state == S_RUN || state_next == S_RUN) begin
      rpt_cnt <= '0;
    end else if (rpt_fire) begin
      rpt_cnt <= RPT_W'(REPEAT_DELAY - REPEAT_PERIOD);
    end else if (rpt_cnt != RPT_W'(REPEAT_DELAY - 1)) begin
      rpt_cnt <= rpt_cnt + 1'b1;
    end
  end

  assign step_req = press_q[STEP_BTN] | rpt_fire;
`else
  // Repeat timing has no effect in this build.
  localparam int unused_repeat_cfg = REPEAT_DELAY + REPEAT_PERIOD;

  assign step_req = press_q[STEP_BTN];
`endif

  // NOTE: next-state is defaulted before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      S_HALT: begin
        if (run_sw)        state_next = S_RUN;
        else if (step_req) state_next = S_STEP;
      end
      S_RUN:   if (!run_sw) state_next = S_HALT;
      S_STEP:  state_next = S_HALT;
      default: state_next = S_HALT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_HALT;
      cpu_en_q   <= 1'b0;
      en_count_q <= '0;
    end else begin
      state    <= state_next;
      cpu_en_q <= (state_next != S_HALT);
      if (cpu_en_q) en_count_q <= en_count_q + 32'd1;
    end
  end

  assign io.sw_sync     = sw_s2;
  assign io.btn_level   = level_q;
  assign io.btn_press   = press_q;
  assign io.btn_release = rel_q;
  assign io.cpu_en      = cpu_en_q;
  assign io.halted      = (state == S_HALT);
  assign io.en_count    = en_count_q;

endmodule

// File: doc/panel_input.md
Name: panel_input

Overview:
- Input-side companion to the board display path: turns raw board switches and push-buttons into clean, clock-aligned controls for the multi-cycle MIPS core.
- Synchronizes switches, debounces buttons and emits one-cycle press/release pulses.
- Runs a run/halt/single-step FSM that drives the CPU clock-enable.
- Sits between the top-level board pins and the CPU/display wrapper, in the CPU clock domain.

Parameters:
- NUM_SW, 16, number of switch inputs.
- NUM_BTN, 5, number of push-button inputs.
- DEBOUNCE_CYCLES, 16, consecutive stable cycles required to accept a button change (≥2).
- RUN_SW, 0, index into sw_sync selecting continuous-run mode.
- STEP_BTN, 0, index into btn_raw used as the single-step button.
- REPEAT_DELAY, 64, hold cycles before the first auto-repeat step (AUTOREPEAT_EN only).
- REPEAT_PERIOD, 16, cycles between subsequent auto-repeat steps (AUTOREPEAT_EN only).

Ports:
- clock  input  1  single system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- sw_raw  input  NUM_SW  asynchronous board switches.
- btn_raw  input  NUM_BTN  asynchronous, bouncing buttons (1 = pressed).
- sw_sync  output  NUM_SW  2-flop synchronized switches.
- btn_level  output  NUM_BTN  debounced button levels.
- btn_press  output  NUM_BTN  one-cycle pulse on each debounced 0→1 transition.
- btn_release  output  NUM_BTN  one-cycle pulse on each debounced 1→0 transition.
- cpu_en  output  1  CPU clock-enable.
- halted  output  1  1 while the FSM is in HALT.
- en_count  output  32  number of cycles in which cpu_en was 1.

Behaviour:
- Reset: every synchronizer flop, sw_sync, btn_level, btn_press, btn_release, cpu_en, en_count and all debounce counters go to 0. FSM goes to HALT, so halted=1.
- Reset has priority over all other events, including a count or transition in progress.
- Switch sync: two flop stages per bit. A change on sw_raw before edge k is visible on sw_sync after edge k+1. No debounce on switches.
- Button sync: each btn_raw bit also passes through two flop stages, giving s2.
- Debounce, per button:
  - If s2 == btn_level, the counter clears to 0.
  - Otherwise the counter increments.
  - When the counter equals DEBOUNCE_CYCLES-1 and s2 still differs, btn_level takes s2 on that edge and the counter clears.
  - Net latency from a stable raw change to btn_level is 2+DEBOUNCE_CYCLES edges.
  - A glitch shorter than DEBOUNCE_CYCLES cycles produces no change and no pulse.
- Pulses: btn_press / btn_release are registered in the same edge that updates btn_level, so each is high exactly one cycle, aligned with the first cycle of the new level.
- FSM states are HALT, RUN and STEP; cpu_en is registered.
  - HALT: if sw_sync[RUN_SW]=1, go to RUN. Else if btn_press[STEP_BTN]=1, go to STEP. Otherwise stay. cpu_en=0.
  - RUN: cpu_en=1 every cycle. When sw_sync[RUN_SW]=0, go to HALT; cpu_en is 0 from that cycle on. Step presses are ignored.
  - STEP: cpu_en=1 for exactly one cycle, then HALT unconditionally.
  - Simultaneous run-switch high and step press in HALT: RUN wins and the step is dropped.
  - A step press while in STEP is dropped.
- en_count: increments on every edge where cpu_en=1 and wraps from 0xFFFFFFFF to 0.
- halted = (state == HALT).

Optional Feature:
- Macro: PANEL_INPUT_AUTOREPEAT_EN.
- When defined:
  - While in HALT with btn_level[STEP_BTN] held, a repeat counter runs.
  - After REPEAT_DELAY cycles of hold following the press, the FSM enters STEP once.
  - It then enters STEP again every REPEAT_PERIOD cycles until release.
  - Releasing the button, or leaving HALT for RUN, clears the repeat counter.
- When not defined:
  - No repeat logic is built.
  - Exactly one step per debounced press.
  - REPEAT_DELAY and REPEAT_PERIOD are unused.

Test Plan (DEBOUNCE_CYCLES=4; REPEAT_DELAY=8, REPEAT_PERIOD=4 where applicable):
- Hold reset 3 cycles with sw_raw=16'hFFFF and btn_raw=5'h1F → all outputs 0 and halted=1 throughout. After release, sw_sync=16'hFFFF two edges later.
- btn_raw[1] pulsed high for 3 cycles, then low → btn_level[1] stays 0, no btn_press. Then hold high 10 cycles → btn_level[1]=1 exactly 6 edges after the rise, and btn_press[1] high for one cycle.
- Bounce pattern 1,0,1,0,1 then stable 1 on btn_raw[0] → exactly one btn_press[0]. Then a stable release → exactly one btn_release[0].
- sw_raw[0]=0, three clean step presses → cpu_en high for exactly 3 isolated cycles, en_count=3, halted back to 1 after each.
- sw_raw[0]=1 for 20 cycles with a step press in the middle → cpu_en continuous for 20 cycles, en_count=20, no extra step. After sw_raw[0] drops, cpu_en falls and halted=1.
- Only with PANEL_INPUT_AUTOREPEAT_EN: hold STEP_BTN 30 cycles after debounce → first step at press+8, then one every 4 cycles until release. Without the macro, exactly 1 step.
